// File: rtl/hwpf_stride_dir_pkg.sv
// Shared types for the stride/direction prefetch engine: FSM states, CSR layouts and
// the signed address step helper.
package hwpf_stride_dir_pkg;

    localparam int unsigned NlineW    = 26;
    localparam int unsigned StrideW   = 16;
    localparam int unsigned NlinesW   = 8;
    localparam int unsigned NblocksW  = 16;
    localparam int unsigned NwaitW    = 16;
    localparam int unsigned InflightW = 8;
    localparam int unsigned TrigW     = 4;
    localparam int unsigned StatW     = 32;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StSend,
        StWait,
        StDone,
        StAbort
    } state_e;

    typedef struct packed {
        logic              enable;
        logic              rearm;
        logic              cycle;
        logic              desc;
        logic [NlineW-1:0] nline;
    } base_csr_t;

    typedef struct packed {
        logic [StrideW-1:0]  stride;
        logic [NlinesW-1:0]  nlines;
        logic [NblocksW-1:0] nblocks;
        logic [TrigW-1:0]    trig;
    } param_csr_t;

    typedef struct packed {
        logic [NwaitW-1:0]    nwait;
        logic [InflightW-1:0] ninflight;
    } thr_csr_t;

    // Two's-complement nline delta; callers add it modulo 2^NlineW.
    function automatic logic [NlineW-1:0] calc_step(input logic               desc,
                                                    input logic [StrideW-1:0] stride,
                                                    input logic               by_block);
        logic [NlineW-1:0] mag;
        mag = by_block ? (NlineW'(stride) + NlineW'(1)) : NlineW'(1);
        return desc ? (~mag + NlineW'(1)) : mag;
    endfunction

endpackage

// File: rtl/hwpf_stride_dir_cnt.sv
// Saturating up/down in-flight counter with limit compare on the current and next count.
module hwpf_stride_dir_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         at_limit_o,
    output logic         at_limit_nxt_o
);

    logic [W-1:0] count_q, count_d;
    logic         dec_ok;

    always_comb begin
        count_d = count_q;
        dec_ok  = dec_i && (count_q != '0);
        if (inc_i && !dec_ok) begin
            if (count_q != '1) count_d = count_q + 1'b1;
        end else if (dec_ok && !inc_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    // A zero limit means unlimited.
    assign at_limit_o     = (limit_i != '0) && (count_q >= limit_i);
    assign at_limit_nxt_o = (limit_i != '0) && (count_d >= limit_i);
    assign count_o        = count_q;

endmodule

// File: rtl/hwpf_stride_dir.sv
// Linear stride prefetch engine with direction, trigger confirmation, in-flight throttling
// and an issued-request counter. One instance per stream.
module hwpf_stride_dir
    import hwpf_stride_dir_pkg::*;
#(
    parameter int unsigned NLINE_W    = NlineW,
    parameter int unsigned STRIDE_W   = StrideW,
    parameter int unsigned NLINES_W   = NlinesW,
    parameter int unsigned NBLOCKS_W  = NblocksW,
    parameter int unsigned NWAIT_W    = NwaitW,
    parameter int unsigned INFLIGHT_W = InflightW,
    parameter int unsigned TRIG_W     = TrigW,
    parameter int unsigned STAT_W     = StatW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  base_set_i,
    input  logic                  base_enable_i,
    input  logic                  base_rearm_i,
    input  logic                  base_cycle_i,
    input  logic                  base_desc_i,
    input  logic [NLINE_W-1:0]    base_nline_i,
    input  logic                  param_set_i,
    input  logic [STRIDE_W-1:0]   param_stride_i,
    input  logic [NLINES_W-1:0]   param_nlines_i,
    input  logic [NBLOCKS_W-1:0]  param_nblocks_i,
    input  logic [TRIG_W-1:0]     param_trig_i,
    input  logic                  thr_set_i,
    input  logic [NWAIT_W-1:0]    thr_nwait_i,
    input  logic [INFLIGHT_W-1:0] thr_ninflight_i,
    output logic                  base_enable_o,
    output logic                  base_rearm_o,
    output logic                  base_cycle_o,
    output logic                  base_desc_o,
    output logic [NLINE_W-1:0]    base_nline_o,
    output logic                  busy_o,
    output logic [NLINE_W-1:0]    snoop_nline_o,
    input  logic                  snoop_match_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output logic [NLINE_W-1:0]    req_nline_o,
    input  logic                  rsp_valid_i,
    output logic [STAT_W-1:0]     stat_issued_o
);

    state_e                state_q, state_d;
    base_csr_t             csr_base_q, csr_base_d, sh_base_q, sh_base_d;
    param_csr_t            csr_param_q, csr_param_d, sh_param_q, sh_param_d;
    thr_csr_t              csr_thr_q, csr_thr_d, sh_thr_q, sh_thr_d;
    logic [TRIG_W-1:0]     trig_cnt_q, trig_cnt_d;
    logic [NWAIT_W-1:0]    nwait_cnt_q, nwait_cnt_d;
    logic [NBLOCKS_W-1:0]  blocks_left_q, blocks_left_d;
    logic [NLINES_W-1:0]   lines_left_q, lines_left_d;
    logic [NLINE_W-1:0]    req_nline_q, req_nline_d;
    logic [STAT_W-1:0]     stat_q, stat_d;

    logic [NLINE_W-1:0]    step_line, step_block, next_block;
    logic [TRIG_W:0]       trig_thresh, trig_next;
    logic [INFLIGHT_W-1:0] inflight;
    logic                  at_limit, at_limit_nxt, accept, enable, last;

    assign enable      = csr_base_q.enable;
    assign step_line   = calc_step(sh_base_q.desc, sh_param_q.stride, 1'b0);
    assign step_block  = calc_step(sh_base_q.desc, sh_param_q.stride, 1'b1);
    assign next_block  = sh_base_q.nline + step_block;
    assign trig_thresh = (sh_param_q.trig == '0) ? (TRIG_W + 1)'(1) : {1'b0, sh_param_q.trig};
    assign trig_next   = {1'b0, trig_cnt_q} + 1'b1;
    assign last        = (blocks_left_q == '0) && (lines_left_q == '0);

    hwpf_stride_dir_cnt #(
        .W (INFLIGHT_W)
    ) u_cnt (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inc_i          (accept),
        .dec_i          (rsp_valid_i),
        .limit_i        (sh_thr_q.ninflight),
        .count_o        (inflight),
        .at_limit_o     (at_limit),
        .at_limit_nxt_o (at_limit_nxt)
    );

    always_comb begin
        state_d       = state_q;
        csr_base_d    = csr_base_q;
        csr_param_d   = csr_param_q;
        csr_thr_d     = csr_thr_q;
        sh_base_d     = sh_base_q;
        sh_param_d    = sh_param_q;
        sh_thr_d      = sh_thr_q;
        trig_cnt_d    = trig_cnt_q;
        nwait_cnt_d   = nwait_cnt_q;
        blocks_left_d = blocks_left_q;
        lines_left_d  = lines_left_q;
        req_nline_d   = req_nline_q;
        stat_d        = stat_q;
        accept        = 1'b0;
        busy_o        = 1'b0;
        req_valid_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    if ((csr_param_q.nlines != '0) || (csr_param_q.nblocks != '0)) begin
                        sh_base_d  = csr_base_q;
                        sh_param_d = csr_param_q;
                        sh_thr_d   = csr_thr_q;
                        trig_cnt_d = '0;
                        state_d    = StArmed;
                    end else begin
                        csr_base_d.enable = 1'b0;
                    end
                end
            end
            StArmed: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (snoop_match_i) begin
                    trig_cnt_d = trig_cnt_q + 1'b1;
                    if (trig_next >= trig_thresh) begin
                        state_d = StSend;
                        if (sh_param_q.nlines == '0) begin
                            req_nline_d     = next_block;
                            sh_base_d.nline = next_block;
                            blocks_left_d   = (sh_param_q.nblocks == '0) ? '0
                                                                         : sh_param_q.nblocks - 1'b1;
                            lines_left_d    = '0;
                        end else begin
                            req_nline_d   = sh_base_q.nline + step_line;
                            blocks_left_d = sh_param_q.nblocks;
                            lines_left_d  = sh_param_q.nlines - 1'b1;
                        end
                    end
                end
            end
            StSend: begin
                busy_o      = 1'b1;
                req_valid_o = 1'b1;
                accept      = req_ready_i;
                if (!enable) begin
                    state_d = StAbort;
                end else if (req_ready_i) begin
                    // The final request leaves the addresses untouched so the written-back
                    // base is the start of the last block.
                    if (last) begin
                        state_d = StDone;
                    end else begin
                        if (lines_left_q == '0) begin
                            req_nline_d     = next_block;
                            sh_base_d.nline = next_block;
                            blocks_left_d   = (blocks_left_q == '0) ? '0 : blocks_left_q - 1'b1;
                            lines_left_d    = sh_param_q.nlines;
                        end else begin
                            req_nline_d  = req_nline_q + step_line;
                            lines_left_d = lines_left_q - 1'b1;
                        end
                        if (sh_thr_q.nwait != '0) begin
                            state_d     = StWait;
                            nwait_cnt_d = sh_thr_q.nwait;
                        end else if (at_limit_nxt) begin
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                busy_o = 1'b1;
                if (nwait_cnt_q != '0) nwait_cnt_d = nwait_cnt_q - 1'b1;
                if (!enable) begin
                    state_d = StAbort;
                end else if ((nwait_cnt_q == '0) && !at_limit) begin
                    state_d = StSend;
                end
            end
            StDone: begin
                busy_o = 1'b1;
                if (nwait_cnt_q != '0) nwait_cnt_d = nwait_cnt_q - 1'b1;
                if (!enable) begin
                    state_d = StAbort;
                end else if ((inflight == '0) && (nwait_cnt_q == '0)) begin
                    csr_base_d.nline = sh_base_q.nline;
                    if (sh_base_q.rearm) begin
                        state_d    = StArmed;
                        trig_cnt_d = '0;
                    end else begin
                        csr_base_d.enable = 1'b0;
                        state_d           = StIdle;
                    end
                    if (sh_base_q.cycle) sh_base_d.nline = csr_base_q.nline;
                end
            end
            StAbort: begin
                busy_o = 1'b1;
                if (inflight == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept && (stat_q != '1)) stat_d = stat_q + 1'b1;

        // Software writes win over the engine's own write-back.
        if (base_set_i) begin
            csr_base_d = '{enable: base_enable_i, rearm: base_rearm_i, cycle: base_cycle_i,
                           desc: base_desc_i, nline: base_nline_i};
        end
        if (param_set_i) begin
            csr_param_d = '{stride: param_stride_i, nlines: param_nlines_i,
                            nblocks: param_nblocks_i, trig: param_trig_i};
            stat_d      = '0;
        end
        if (thr_set_i) begin
            csr_thr_d = '{nwait: thr_nwait_i, ninflight: thr_ninflight_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            csr_base_q    <= '0;
            csr_param_q   <= '0;
            csr_thr_q     <= '0;
            sh_base_q     <= '0;
            sh_param_q    <= '0;
            sh_thr_q      <= '0;
            trig_cnt_q    <= '0;
            nwait_cnt_q   <= '0;
            blocks_left_q <= '0;
            lines_left_q  <= '0;
            req_nline_q   <= '0;
            stat_q        <= '0;
        end else begin
            state_q       <= state_d;
            csr_base_q    <= csr_base_d;
            csr_param_q   <= csr_param_d;
            csr_thr_q     <= csr_thr_d;
            sh_base_q     <= sh_base_d;
            sh_param_q    <= sh_param_d;
            sh_thr_q      <= sh_thr_d;
            trig_cnt_q    <= trig_cnt_d;
            nwait_cnt_q   <= nwait_cnt_d;
            blocks_left_q <= blocks_left_d;
            lines_left_q  <= lines_left_d;
            req_nline_q   <= req_nline_d;
            stat_q        <= stat_d;
        end
    end

    assign base_enable_o = csr_base_q.enable;
    assign base_rearm_o  = csr_base_q.rearm;
    assign base_cycle_o  = csr_base_q.cycle;
    assign base_desc_o   = csr_base_q.desc;
    assign base_nline_o  = csr_base_q.nline;
    assign snoop_nline_o = sh_base_q.nline;
    assign req_nline_o   = req_nline_q;
    assign stat_issued_o = stat_q;

endmodule

// File: tb/tb_hwpf_stride_dir.sv
// Directed bench for hwpf_stride_dir: bursts in both directions, trigger confirmation,
// in-flight throttling, abort and rearm/cycle behaviour.
module tb_hwpf_stride_dir;

    logic        clk = 1'b0;
    logic        rst;
    logic        base_set, base_enable, base_rearm, base_cycle, base_desc;
    logic [25:0] base_nline;
    logic        param_set;
    logic [15:0] param_stride;
    logic [7:0]  param_nlines;
    logic [15:0] param_nblocks;
    logic [3:0]  param_trig;
    logic        thr_set;
    logic [15:0] thr_nwait;
    logic [7:0]  thr_ninflight;
    logic        base_enable_o, base_rearm_o, base_cycle_o, base_desc_o;
    logic [25:0] base_nline_o;
    logic        busy;
    logic [25:0] snoop_nline;
    logic        snoop_match;
    logic        req_valid, req_ready;
    logic [25:0] req_nline;
    logic        rsp_valid;
    logic [31:0] stat_issued;

    int          checks = 0;
    int          errors = 0;
    logic [25:0] got [0:15];
    int          got_n;

    hwpf_stride_dir dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .base_set_i      (base_set),
        .base_enable_i   (base_enable),
        .base_rearm_i    (base_rearm),
        .base_cycle_i    (base_cycle),
        .base_desc_i     (base_desc),
        .base_nline_i    (base_nline),
        .param_set_i     (param_set),
        .param_stride_i  (param_stride),
        .param_nlines_i  (param_nlines),
        .param_nblocks_i (param_nblocks),
        .param_trig_i    (param_trig),
        .thr_set_i       (thr_set),
        .thr_nwait_i     (thr_nwait),
        .thr_ninflight_i (thr_ninflight),
        .base_enable_o   (base_enable_o),
        .base_rearm_o    (base_rearm_o),
        .base_cycle_o    (base_cycle_o),
        .base_desc_o     (base_desc_o),
        .base_nline_o    (base_nline_o),
        .busy_o          (busy),
        .snoop_nline_o   (snoop_nline),
        .snoop_match_i   (snoop_match),
        .req_valid_o     (req_valid),
        .req_ready_i     (req_ready),
        .req_nline_o     (req_nline),
        .rsp_valid_i     (rsp_valid),
        .stat_issued_o   (stat_issued)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_base(input logic en, input logic rearm, input logic cyc,
                              input logic desc, input logic [25:0] nline);
        base_enable = en; base_rearm = rearm; base_cycle = cyc; base_desc = desc;
        base_nline = nline; base_set = 1'b1;
        tick();
        base_set = 1'b0;
    endtask

    task automatic write_param(input logic [15:0] stride, input logic [7:0] nlines,
                               input logic [15:0] nblocks, input logic [3:0] trig);
        param_stride = stride; param_nlines = nlines; param_nblocks = nblocks;
        param_trig = trig; param_set = 1'b1;
        tick();
        param_set = 1'b0;
    endtask

    task automatic write_thr(input logic [15:0] nwait, input logic [7:0] ninflight);
        thr_nwait = nwait; thr_ninflight = ninflight; thr_set = 1'b1;
        tick();
        thr_set = 1'b0;
    endtask

    task automatic snoop_hit();
        snoop_match = 1'b1;
        tick();
        snoop_match = 1'b0;
    endtask

    task automatic rsp_pulse();
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
    endtask

    // Records up to n accepted requests; caller holds req_ready high.
    task automatic collect(input int n);
        int cyc = 0;
        got_n = 0;
        while (got_n < n && cyc < 200) begin
            if (req_valid) begin
                got[got_n] = req_nline;
                got_n++;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic count_reqs(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (req_valid && req_ready) n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", req_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (snoop_nline !== 26'h0) begin errors++; $display("FAIL rst_snoop got %h want 0", snoop_nline); end
        checks++; if (stat_issued !== 32'h0) begin errors++; $display("FAIL rst_stat got %0d want 0", stat_issued); end
        checks++; if ({base_enable_o, base_nline_o} !== 27'h0) begin errors++; $display("FAIL rst_csr got %h want 0", {base_enable_o, base_nline_o}); end
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_ascending();
        logic [25:0] exp [5] = '{26'h101, 26'h104, 26'h105, 26'h108, 26'h109};
        write_param(16'd3, 8'd1, 16'd2, 4'd0);
        write_thr(16'd0, 8'd0);
        write_base(1'b1, 1'b0, 1'b0, 1'b0, 26'h100);
        tick();
        checks++; if (snoop_nline !== 26'h100) begin errors++; $display("FAIL asc_snoop got %h want 100", snoop_nline); end
        req_ready = 1'b1;
        snoop_hit();
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL asc_latency got %b want 1", req_valid); end
        collect(5);
        checks++; if (got_n !== 5) begin errors++; $display("FAIL asc_count got %0d want 5", got_n); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL asc_req%0d got %h want %h", i, got[i], exp[i]); end
        end
        checks++; if ({busy, req_valid} !== 2'b10) begin errors++; $display("FAIL asc_done got %b want 10", {busy, req_valid}); end
        checks++; if (stat_issued !== 32'd5) begin errors++; $display("FAIL asc_stat got %0d want 5", stat_issued); end
        for (int i = 0; i < 5; i++) rsp_pulse();
        tick();
        checks++; if (base_nline_o !== 26'h108) begin errors++; $display("FAIL asc_wb got %h want 108", base_nline_o); end
        checks++; if ({base_enable_o, busy} !== 2'b00) begin errors++; $display("FAIL asc_idle got %b want 00", {base_enable_o, busy}); end
    endtask

    task automatic test_desc_wrap();
        logic [25:0] exp [3] = '{26'h0, 26'h3FFFFFF, 26'h3FFFFFE};
        write_param(16'd0, 8'd0, 16'd3, 4'd0);
        write_base(1'b1, 1'b0, 1'b0, 1'b1, 26'h1);
        tick();
        req_ready = 1'b1;
        snoop_hit();
        collect(3);
        checks++; if (got_n !== 3) begin errors++; $display("FAIL desc_count got %0d want 3", got_n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL desc_req%0d got %h want %h", i, got[i], exp[i]); end
        end
        checks++; if (stat_issued !== 32'd3) begin errors++; $display("FAIL desc_stat got %0d want 3", stat_issued); end
        for (int i = 0; i < 3; i++) rsp_pulse();
        tick();
        checks++; if (base_nline_o !== 26'h3FFFFFE) begin errors++; $display("FAIL desc_wb got %h want 3fffffe", base_nline_o); end
        checks++; if (base_enable_o !== 1'b0) begin errors++; $display("FAIL desc_en got %b want 0", base_enable_o); end
    endtask

    task automatic test_trigger();
        write_param(16'd0, 8'd0, 16'd1, 4'd3);
        write_base(1'b1, 1'b0, 1'b0, 1'b0, 26'h40);
        tick();
        req_ready = 1'b0;
        snoop_hit();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL trig_hit1 got %b want 0", req_valid); end
        snoop_hit();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL trig_hit2 got %b want 0", req_valid); end
        snoop_hit();
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL trig_hit3 got %b want 1", req_valid); end
        checks++; if (req_nline !== 26'h41) begin errors++; $display("FAIL trig_addr got %h want 41", req_nline); end
        tick();
        checks++; if (req_nline !== 26'h41) begin errors++; $display("FAIL trig_hold got %h want 41", req_nline); end
        req_ready = 1'b1;
        collect(1);
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL trig_single got %b want 0", req_valid); end
        rsp_pulse();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trig_idle got %b want 0", busy); end
    endtask

    task automatic test_throttle();
        int n;
        int waited;
        write_thr(16'd0, 8'd2);
        write_param(16'd0, 8'd0, 16'd20, 4'd0);
        write_base(1'b1, 1'b0, 1'b0, 1'b0, 26'h500);
        tick();
        req_ready = 1'b1;
        snoop_hit();
        count_reqs(10, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL thr_limit got %0d want 2", n); end
        checks++; if ({busy, req_valid} !== 2'b10) begin errors++; $display("FAIL thr_wait got %b want 10", {busy, req_valid}); end
        rsp_pulse();
        count_reqs(8, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL thr_one_more got %0d want 1", n); end
        rsp_pulse();
        waited = 0;
        while (!req_valid && waited < 10) begin
            tick();
            waited++;
        end
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL thr_resend got %b want 1", req_valid); end
        rsp_valid = 1'b1;
        tick();
        rsp_valid = 1'b0;
        count_reqs(8, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL thr_simul got %0d want 1", n); end
        req_ready = 1'b0;
        write_base(1'b0, 1'b0, 1'b0, 1'b0, 26'h500);
        tick();
        rsp_pulse();
        rsp_pulse();
        tick();
        checks++; if ({busy, req_valid} !== 2'b00) begin errors++; $display("FAIL thr_drain got %b want 00", {busy, req_valid}); end
    endtask

    task automatic test_abort();
        write_thr(16'd0, 8'd0);
        write_param(16'd0, 8'd0, 16'd50, 4'd0);
        write_base(1'b1, 1'b0, 1'b0, 1'b0, 26'h600);
        tick();
        req_ready = 1'b1;
        snoop_hit();
        collect(3);
        req_ready = 1'b0;
        checks++; if (got[2] !== 26'h603) begin errors++; $display("FAIL abort_req got %h want 603", got[2]); end
        write_base(1'b0, 1'b0, 1'b0, 1'b0, 26'h600);
        tick();
        req_ready = 1'b1;
        checks++; if ({busy, req_valid} !== 2'b10) begin errors++; $display("FAIL abort_state got %b want 10", {busy, req_valid}); end
        rsp_pulse();
        rsp_pulse();
        checks++; if ({busy, req_valid} !== 2'b10) begin errors++; $display("FAIL abort_hold got %b want 10", {busy, req_valid}); end
        rsp_pulse();
        tick();
        checks++; if ({busy, req_valid} !== 2'b00) begin errors++; $display("FAIL abort_idle got %b want 00", {busy, req_valid}); end
        checks++; if (stat_issued !== 32'd3) begin errors++; $display("FAIL abort_stat got %0d want 3", stat_issued); end
    endtask

    task automatic test_rearm_cycle();
        write_param(16'd0, 8'd0, 16'd1, 4'd0);
        write_base(1'b1, 1'b1, 1'b1, 1'b0, 26'h200);
        tick();
        req_ready = 1'b1;
        snoop_hit();
        collect(1);
        checks++; if (got[0] !== 26'h201) begin errors++; $display("FAIL rearm_req got %h want 201", got[0]); end
        checks++; if (stat_issued !== 32'd1) begin errors++; $display("FAIL rearm_stat got %0d want 1", stat_issued); end
        rsp_pulse();
        tick();
        checks++; if (snoop_nline !== 26'h200) begin errors++; $display("FAIL rearm_snoop got %h want 200", snoop_nline); end
        checks++; if (base_nline_o !== 26'h201) begin errors++; $display("FAIL rearm_wb got %h want 201", base_nline_o); end
        checks++; if ({busy, base_enable_o} !== 2'b01) begin errors++; $display("FAIL rearm_armed got %b want 01", {busy, base_enable_o}); end
        snoop_hit();
        collect(1);
        checks++; if (got[0] !== 26'h201) begin errors++; $display("FAIL rearm_req2 got %h want 201", got[0]); end
        rsp_pulse();
        write_base(1'b1, 1'b0, 1'b0, 1'b0, 26'h333);
        checks++; if (base_nline_o !== 26'h333) begin errors++; $display("FAIL rearm_prio got %h want 333", base_nline_o); end
        checks++; if (base_rearm_o !== 1'b0) begin errors++; $display("FAIL rearm_prio_flag got %b want 0", base_rearm_o); end
        write_base(1'b0, 1'b0, 1'b0, 1'b0, 26'h333);
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rearm_end got %b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        base_set = 1'b0; base_enable = 1'b0; base_rearm = 1'b0; base_cycle = 1'b0;
        base_desc = 1'b0; base_nline = '0;
        param_set = 1'b0; param_stride = '0; param_nlines = '0; param_nblocks = '0;
        param_trig = '0;
        thr_set = 1'b0; thr_nwait = '0; thr_ninflight = '0;
        snoop_match = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
        test_reset();
        test_ascending();
        test_desc_wrap();
        test_trigger();
        test_throttle();
        test_abort();
        test_rearm_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
